rv_wb_arbiter: RTL
==================

# rv_wb_arbiter

Two-port Wishbone classic arbiter sharing the core's single external bus between the instruction-fetch port and the load/store port. Sits between the pipeline stages and the `o_wb_*` bus pins; replaces stage-based bus multiplexing so fetch and memory stages can issue requests independently. Round-robin grant with a per-transaction bus watchdog that returns an error instead of hanging the core.

## Interface
- `TIMEOUT_CYCLES`, 255 — cycles a granted transaction may wait for `i_wb_ack` before being aborted with error; 0 disables the watchdog.
- `i_clk`  in  1  core clock; all logic on rising edge.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_ib_adr`  in  32  fetch address; bits [1:0] ignored.
- `i_ib_stb`  in  1  fetch request, held until `o_ib_ack`/`o_ib_err`.
- `o_ib_dat`  out  32  fetch read data.
- `o_ib_ack`  out  1  fetch done, single cycle.
- `o_ib_err`  out  1  fetch timed out, single cycle.
- `i_db_adr`  in  32  load/store address.
- `i_db_dat`  in  32  store data.
- `i_db_we`  in  1  1 = store.
- `i_db_sel`  in  4  byte lanes.
- `i_db_stb`  in  1  load/store request, held until ack/err.
- `o_db_dat`  out  32  load data.
- `o_db_ack`  out  1  load/store done.
- `o_db_err`  out  1  load/store timed out.
- `o_wb_adr`, `o_wb_dat`, `o_wb_we`, `o_wb_sel`, `o_wb_stb`, `o_wb_cyc`  out  32/32/1/4/1/1  master bus.
- `i_wb_dat`, `i_wb_ack`  in  32/1  slave response.

## Operation
- States: IDLE, GRANT_I, GRANT_D. Reset → IDLE, `r_last_d` = 0, watchdog count = 0.
- IDLE: only `i_ib_stb` → GRANT_I; only `i_db_stb` → GRANT_D; both → port not served last (`r_last_d` = 1 → I, else D). Neither → stay.
- GRANT_x: `o_wb_cyc` = `o_wb_stb` = granted port's stb. Address/data/we/sel driven from granted port; GRANT_I forces `o_wb_we` = 0, `o_wb_sel` = 4'hF. `o_wb_adr` = {adr[31:2], 2'b00}.
- IDLE: all `o_wb_*` outputs 0.
- `i_wb_ack` while `o_wb_cyc` = 1 routes combinationally to the granted port's ack. Next edge → IDLE; `r_last_d` updated (1 after D, 0 after I).
- `i_wb_ack` with `o_wb_cyc` = 0 is ignored.
- Granted port drops stb before ack (abort): cyc/stb fall the same cycle. Next edge → IDLE, no ack, `r_last_d` updated.
- `o_ib_dat` and `o_db_dat` both equal `i_wb_dat` unconditionally. They are valid only with the respective ack.
- Watchdog:
  - Counts cycles in GRANT_x without ack; clears on entering IDLE.
  - When count == TIMEOUT_CYCLES-1 and no ack, pulse the granted port's err for one cycle. Cyc/stb are driven 0 that cycle. Next edge → IDLE.
  - Ack and timeout in the same cycle: ack wins, no err.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it must not wrap.

## Timing
- Request seen high at edge N → `o_wb_cyc`/`o_wb_stb` high after edge N (one-cycle grant latency).
- Zero-wait slave: ack in the first grant cycle → port ack after edge N. Port read latency = 1 grant cycle + slave wait states.
- One IDLE cycle (cyc = 0) between consecutive transactions. Throughput ≤ 1 transfer per 2 cycles.
- Reset assertion mid-transaction: all outputs 0 immediately (asynchronous); no ack/err delivered.
- All port acks/errs: mutually exclusive, never both ports in one cycle.

## Structure
- Shared package `rv_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}.
  - Constant `WB_SEL_WORD` = 4'hF.
- One sub-module `rv_bus_watchdog` (parameter TIMEOUT_CYCLES; inputs i_clk, i_reset_n, i_run, i_clear; output o_expired). Instantiated once.

## Test plan
- Reset mid-GRANT_D with `i_wb_dat`=0x12345678, ack high → all outputs 0 during reset, state IDLE after release, no ack seen.
- Fetch only, adr 0x0000_0104, slave ack on 3rd grant cycle → `o_wb_adr`=0x104, sel=4'hF, we=0 for 3 cycles. `o_ib_ack` with `o_ib_dat`=slave data; cyc low next cycle.
- Both requesting from reset, zero-wait slave → grants D, I, D, I alternating. Cyc pattern 1,0,1,0; store adr 0x2000, dat 0xDEADBEEF, sel 4'b0011 on D grants.
- TIMEOUT_CYCLES=4, slave never acks → `o_db_err` single pulse in 4th grant cycle with cyc=0. Then I (waiting) granted after one IDLE cycle.
- Ack coinciding with timeout cycle → `o_ib_ack`=1, `o_ib_err`=0. Spurious `i_wb_ack` in IDLE → no port ack.
- Data port drops stb after 2 grant cycles without ack → cyc falls same cycle, no `o_db_ack`/`o_db_err`. Pending fetch granted next.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and constants for the core's bus arbitration logic.
package rv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_I,
    ARB_GRANT_D
  } arb_state_t;

  localparam logic [3:0] WB_SEL_WORD = 4'hF;

endpackage

// File: rtl/rv_bus_watchdog.sv
// Per-transaction bus watchdog: counts waiting cycles and flags the last one allowed.
module rv_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] r_count;

  // Saturates at LAST so the count can never wrap back to zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT_CYCLES != 0) && i_run && (r_count == LAST);

endmodule

// File: rtl/rv_wb_arbiter.sv
// Round-robin Wishbone classic arbiter between the fetch and load/store ports,
// with a watchdog that turns a hung slave into a port error.
module rv_wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_ib_adr,
  input  logic        i_ib_stb,
  output logic [31:0] o_ib_dat,
  output logic        o_ib_ack,
  output logic        o_ib_err,
  input  logic [31:0] i_db_adr,
  input  logic [31:0] i_db_dat,
  input  logic        i_db_we,
  input  logic [3:0]  i_db_sel,
  input  logic        i_db_stb,
  output logic [31:0] o_db_dat,
  output logic        o_db_ack,
  output logic        o_db_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack
);

  arb_state_t r_state, state_next;
  logic       r_last_d, last_d_next;
  logic       wd_run, wd_clear, wd_expired;
  logic       timeout;

  // Read data is shared by both ports; held at zero while reset is asserted.
  assign o_ib_dat = i_reset_n ? i_wb_dat : 32'h0;
  assign o_db_dat = i_reset_n ? i_wb_dat : 32'h0;

  assign wd_clear = (r_state == ARB_IDLE);
  assign wd_run   = (r_state != ARB_IDLE) && !i_wb_ack;

  rv_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_run    (wd_run),
    .i_clear  (wd_clear),
    .o_expired(wd_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ARB_IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state  <= state_next;
      r_last_d <= last_d_next;
    end
  end

  always_comb begin
    state_next  = r_state;
    last_d_next = r_last_d;
    timeout     = 1'b0;
    o_wb_adr    = 32'h0;
    o_wb_dat    = 32'h0;
    o_wb_we     = 1'b0;
    o_wb_sel    = 4'h0;
    o_wb_stb    = 1'b0;
    o_wb_cyc    = 1'b0;
    o_ib_ack    = 1'b0;
    o_ib_err    = 1'b0;
    o_db_ack    = 1'b0;
    o_db_err    = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (i_ib_stb && i_db_stb) begin
          state_next = r_last_d ? ARB_GRANT_I : ARB_GRANT_D;
        end else if (i_ib_stb) begin
          state_next = ARB_GRANT_I;
        end else if (i_db_stb) begin
          state_next = ARB_GRANT_D;
        end
      end

      ARB_GRANT_I: begin
        // An ack in the expiry cycle still completes the transfer.
        timeout  = wd_expired && i_ib_stb && !i_wb_ack;
        o_wb_cyc = i_ib_stb && !timeout;
        o_wb_stb = o_wb_cyc;
        o_wb_adr = {i_ib_adr[31:2], 2'b00};
        o_wb_sel = WB_SEL_WORD;
        o_ib_ack = i_wb_ack && o_wb_cyc;
        o_ib_err = timeout;
        if (!o_wb_cyc || i_wb_ack) begin
          state_next  = ARB_IDLE;
          last_d_next = 1'b0;
        end
      end

      ARB_GRANT_D: begin
        timeout  = wd_expired && i_db_stb && !i_wb_ack;
        o_wb_cyc = i_db_stb && !timeout;
        o_wb_stb = o_wb_cyc;
        o_wb_adr = {i_db_adr[31:2], 2'b00};
        o_wb_dat = i_db_dat;
        o_wb_we  = i_db_we;
        o_wb_sel = i_db_sel;
        o_db_ack = i_wb_ack && o_wb_cyc;
        o_db_err = timeout;
        if (!o_wb_cyc || i_wb_ack) begin
          state_next  = ARB_IDLE;
          last_d_next = 1'b1;
        end
      end

      default: state_next = ARB_IDLE;
    endcase
  end

endmodule
